// File: rtl/load_pkg.sv
// load_pkg: shared types for the load unit (FSM states, funct3 encodings, error codes, legality helpers)
package load_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, ERR} state_t;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [1:0] EC_MISALIGN = 2'b01;
    localparam logic [1:0] EC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EC_TIMEOUT  = 2'b11;
    function automatic logic f3_illegal(input logic [2:0] f);
        return !(f inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    endfunction
    function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
        return ((f == F3_LH || f == F3_LHU) && a[0]) || (f == F3_LW && a != 2'b00);
    endfunction
endpackage

// File: rtl/load_unit_if.sv
// load_unit_if: memory read bus; master = load unit (mem_req, mem_addr out; mem_gnt, mem_rvalid, mem_rdata in), slave = memory
interface load_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    modport master(output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
    modport slave(input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/load_extract.sv
// load_extract: selects byte/halfword/word lane of little-endian rdata by ea[1:0] and sign/zero extends (rdata, ea_lo, funct3 in; data out)
module load_extract
    import load_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  ea_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;
    always_comb begin
        b    = rdata[{ea_lo, 3'b000} +: 8];
        h    = rdata[{ea_lo[1], 4'b0000} +: 16];
        sx   = !funct3[2];
        data = funct3 == F3_LW ? rdata :
               funct3[1:0] == 2'b01 ? {{16{sx & h[15]}}, h} : {{24{sx & b[7]}}, b};
    end
endmodule

// File: rtl/load_unit.sv
// load_unit: single-outstanding load FSM (IDLE/REQ/WAIT/WB/ERR)
// ports: clk, reset (sync, active-high); start/base/offset/rd/funct3 request in, ready out;
//        mem (load_unit_if.master) memory bus; reg_write/write_reg/write_data register-file write;
//        done/err one-cycle completion pulses with err_code (01 misaligned, 10 illegal funct3, 11 timeout)
module load_unit
    import load_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base,
    input  logic [15:0] offset,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    output logic        ready,
    load_unit_if.master mem,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t      state, nxt;
    logic [31:0] ea, ea_n, ext;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]  code_n;
    load_extract u_extract (.rdata(mem.mem_rdata), .ea_lo(ea[1:0]), .funct3(f3_q), .data(ext));
    assign ready = state == IDLE;
    always_comb begin
        nxt    = state;
        ea_n   = ea;
        cnt_n  = '0;
        code_n = EC_MISALIGN;
        case (state)
            IDLE: if (start) begin
                ea_n   = base + {{16{offset[15]}}, offset};
                nxt    = f3_illegal(funct3) || misaligned(funct3, ea_n[1:0]) ? ERR : REQ;
                code_n = f3_illegal(funct3) ? EC_ILLEGAL : EC_MISALIGN;
            end
            REQ:  nxt = mem.mem_gnt ? WAIT : REQ;
            WAIT: if (mem.mem_rvalid) nxt = WB;
                  else if (cnt == CW'(TIMEOUT - 1)) begin
                      nxt    = ERR;
                      code_n = EC_TIMEOUT;
                  end else cnt_n = cnt + 1'b1;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they coincide with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ea           <= '0;
            rd_q         <= '0;
            f3_q         <= '0;
            cnt          <= '0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            reg_write    <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= '0;
        end else begin
            state <= nxt;
            ea    <= ea_n;
            cnt   <= cnt_n;
            if (state == IDLE && start) begin
                rd_q <= rd;
                f3_q <= funct3;
            end
            mem.mem_req  <= nxt == REQ;
            mem.mem_addr <= nxt == REQ ? {ea_n[31:2], 2'b00} : '0;
            done         <= nxt == WB;
            reg_write    <= nxt == WB && rd_q != 5'd0;
            write_reg    <= nxt == WB ? rd_q : '0;
            write_data   <= nxt == WB ? ext : '0;
            err          <= nxt == ERR;
            err_code     <= nxt == ERR ? code_n : '0;
        end
    end
endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the max cycles waited for mem_rvalid after grant before error.
REQ-002 Clock clk, input, 1: all state SHALL update on the rising edge.
REQ-003 Reset reset, input, 1: synchronous, active-high.
REQ-004 start, input, 1: load request, SHALL be accepted only when ready=1.
REQ-005 base, input, 32: base register value.
REQ-006 offset, input, 16: signed immediate.
REQ-007 rd, input, 5: destination register index.
REQ-008 funct3, input, 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal.
REQ-009 ready, output, 1: high in IDLE only.
REQ-010 mem_req, output, 1: memory read request.
REQ-011 mem_addr, output, 32: word-aligned address {ea[31:2],2'b00}.
REQ-012 mem_gnt, input, 1: request accepted.
REQ-013 mem_rvalid, input, 1: read data valid.
REQ-014 mem_rdata, input, 32: read data, little-endian.
REQ-015 reg_write, write_reg (5), write_data (32), outputs: register-file write port.
REQ-016 done, output, 1: one-cycle completion pulse.
REQ-017 err, output, 1: one-cycle error pulse; err_code, output, 2: 01 misaligned, 10 illegal funct3, 11 timeout.

Function
REQ-018 States SHALL be IDLE, REQ, WAIT, WB, ERR.
REQ-019 IDLE with start=1 SHALL latch ea = base + sign-extended offset (mod 2^32), rd, and funct3.
REQ-020 From IDLE, an illegal funct3 or misalignment (LH/LHU with ea[0]=1; LW with ea[1:0]!=0) SHALL go to ERR without asserting mem_req.
REQ-021 Otherwise IDLE SHALL go to REQ; mem_req and mem_addr SHALL be held stable until the cycle mem_gnt=1, then go to WAIT.
REQ-022 WAIT SHALL count cycles from 0; on mem_rvalid=1 capture the extracted data and go to WB; if the count reaches TIMEOUT with no rvalid, go to ERR with code 11.
REQ-023 mem_rvalid in the same cycle as mem_gnt SHALL be ignored; mem_rvalid outside WAIT SHALL be ignored.
REQ-024 Byte lane SHALL be mem_rdata[8*ea[1:0] +: 8]; halfword lane SHALL be mem_rdata[16*ea[1] +: 16].
REQ-025 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to 32 bits; LW SHALL pass all 32 bits.
REQ-026 WB SHALL last one cycle with done=1 and write_reg=rd, then return to IDLE.
REQ-027 In WB, reg_write SHALL be 1 with write_data set, except when rd=0: then reg_write=0 and done=1.
REQ-028 ERR SHALL last one cycle with err=1 and err_code valid, then return to IDLE; reg_write SHALL stay 0.
REQ-029 Minimum latency, start to done, SHALL be 4 cycles (gnt and rvalid each one cycle after entering REQ/WAIT); a new start SHALL be accepted in the cycle after done or err.
REQ-030 reg_write, done and err SHALL never be high together, and each SHALL be registered.

Reset
REQ-031 Reset SHALL force IDLE and drive ready=1 and all other outputs to 0: mem_req, mem_addr, reg_write, write_reg, write_data, done, err, err_code.
REQ-032 Reset mid-operation SHALL abandon the load with no register write; a late rvalid after reset SHALL be ignored.

Structure
REQ-033 Package load_pkg SHALL hold the state enum, funct3 constants, and err_code constants.
REQ-034 Sub-module load_extract (combinational: lane select plus extension, inputs rdata/ea[1:0]/funct3) SHALL be instantiated once.

Verification
REQ-035 LW base=0x100, offset=4, rdata=0xDEADBEEF, gnt and rvalid immediate -> mem_addr=0x104; reg_write=1, write_data=0xDEADBEEF at cycle 4.
REQ-036 LB ea=0x103, rdata=0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LH ea=0x102, rdata=0x8001xxxx -> 0xFFFF8001.
REQ-037 LW ea=0x102 -> err=1, code 01, no mem_req; funct3=011 -> code 10.
REQ-038 mem_gnt delayed 3 cycles and rvalid withheld for TIMEOUT=8 -> mem_addr stable while waiting; err code 11 after 8 WAIT cycles; no write.
REQ-039 rd=0 LW -> done=1, reg_write=0; reset asserted in WAIT, then rvalid -> no write, ready=1 the next cycle.
